// File: rtl/ram_pkg.sv
// Shared types and constants for the RAM controller slice: FSM states,
// operation encoding and the storage geometry defaults.
package ram_pkg;

    // Controller FSM states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        ACK     = 2'd2,
        RELEASE = 2'd3
    } state_t;

    // Operation latched when a request is accepted.
    typedef enum logic [1:0] {
        LD_WR  = 2'd0,
        CPU_RD = 2'd1,
        CPU_WR = 2'd2
    } op_t;

    localparam int WORDS_DEFAULT = 64;
    localparam int WORD_IDX_W    = $clog2(WORDS_DEFAULT);

    // A byte address is misaligned when either of its low two bits is set.
    function automatic logic misaligned(input logic [1:0] byte_lsbs);
        return byte_lsbs != 2'b00;
    endfunction

endpackage

// File: rtl/ram_controller_if.sv
// CPU, loader and status signals of the RAM controller, bundled as one bus.
// The master drives requests; the slave (the controller) drives responses.
interface ram_controller_if;
    logic [7:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_read_req;
    logic        cpu_write_req;
    logic [31:0] cpu_rdata;
    logic        cpu_read_ack;
    logic        cpu_write_ack;
    logic [7:0]  ld_addr;
    logic [31:0] ld_wdata;
    logic        ld_write_req;
    logic        ld_write_ack;
    logic        busy;
    logic        err;

    modport master (
        output cpu_addr, cpu_wdata, cpu_read_req, cpu_write_req,
        output ld_addr, ld_wdata, ld_write_req,
        input  cpu_rdata, cpu_read_ack, cpu_write_ack, ld_write_ack, busy, err
    );

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_read_req, cpu_write_req,
        input  ld_addr, ld_wdata, ld_write_req,
        output cpu_rdata, cpu_read_ack, cpu_write_ack, ld_write_ack, busy, err
    );
endinterface

// File: rtl/ram_array.sv
// Single-port synchronous word storage. No reset: contents survive a
// controller reset. The read register only updates when re_i is high so the
// last read value is held between reads.
module ram_array
    import ram_pkg::*;
#(
    parameter int WORDS = WORDS_DEFAULT,
    parameter int IDX_W = $clog2(WORDS)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic             re_i,
    input  logic [IDX_W-1:0] addr_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_o
);

    logic [31:0] mem_q [WORDS];
    logic [31:0] rdata_q;

    // Write commit and registered read on the same port.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_controller.sv
// Request arbiter and handshake FSM in front of ram_array.
// IDLE accepts one request (loader > CPU read > CPU write), optionally waits
// WAIT_STATES cycles, raises the matching ack for one cycle, then parks in
// RELEASE until the served request drops so it is never served twice.
// A request accepted at edge N puts the FSM in ACK after edge N+WAIT_STATES,
// so the requester samples the ack high at edge N+1+WAIT_STATES.
module ram_controller
    import ram_pkg::*;
#(
    parameter int WAIT_STATES = 1,
    parameter int WORDS       = WORDS_DEFAULT
) (
    input  logic           clk,
    input  logic           reset,
    ram_controller_if.slave bus
);

    localparam int         IDX_W     = $clog2(WORDS);
    localparam logic [2:0] WAIT_LAST = 3'(WAIT_STATES - 1);

    state_t      state_q, state_d;
    op_t         op_q, op_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic        rvalid_q;
    logic        served_req;
    logic        enter_ack;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_rdata;

    // Level of the request line belonging to the operation being served.
    always_comb begin
        served_req = 1'b0;
        case (op_q)
            LD_WR:   served_req = bus.ld_write_req;
            CPU_RD:  served_req = bus.cpu_read_req;
            CPU_WR:  served_req = bus.cpu_write_req;
            default: served_req = 1'b0;
        endcase
    end

    // Next-state logic: arbitration, request latching, wait counting.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (bus.ld_write_req || bus.cpu_read_req || bus.cpu_write_req) begin
                    if (bus.ld_write_req) begin
                        op_d    = LD_WR;
                        addr_d  = bus.ld_addr;
                        wdata_d = bus.ld_wdata;
                    end else if (bus.cpu_read_req) begin
                        op_d   = CPU_RD;
                        addr_d = bus.cpu_addr;
                        // Simultaneous read and write: read wins, flag it.
                        if (bus.cpu_write_req) begin
                            err_d = 1'b1;
                        end
                    end else begin
                        op_d    = CPU_WR;
                        addr_d  = bus.cpu_addr;
                        wdata_d = bus.cpu_wdata;
                    end
                    // Misaligned access still proceeds on the word index.
                    if (misaligned(addr_d[1:0])) begin
                        err_d = 1'b1;
                    end
                    cnt_d   = 3'd0;
                    state_d = (WAIT_STATES == 0) ? ACK : WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    cnt_d   = 3'd0;
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ACK:     state_d = RELEASE;
            RELEASE: begin
                if (!served_req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Memory access happens on the edge that enters ACK; reset suppresses it
    // so an uncommitted write is dropped.
    assign enter_ack = (state_d == ACK) && (state_q != ACK);
    assign mem_we    = enter_ack && (op_d != CPU_RD) && !reset;
    assign mem_re    = enter_ack && (op_d == CPU_RD) && !reset;

    ram_array #(
        .WORDS (WORDS),
        .IDX_W (IDX_W)
    ) u_ram_array (
        .clk     (clk),
        .we_i    (mem_we),
        .re_i    (mem_re),
        .addr_i  (addr_d[IDX_W+1:2]),
        .wdata_i (wdata_d),
        .rdata_o (mem_rdata)
    );

    // FSM and request registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= LD_WR;
            cnt_q    <= 3'd0;
            addr_q   <= 8'h00;
            wdata_q  <= 32'h0;
            err_q    <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            rvalid_q <= rvalid_q | mem_re;
        end
    end

    // Read data reads as zero until the first read after reset.
    assign bus.cpu_rdata     = rvalid_q ? mem_rdata : 32'h0;
    assign bus.ld_write_ack  = (state_q == ACK) && (op_q == LD_WR);
    assign bus.cpu_read_ack  = (state_q == ACK) && (op_q == CPU_RD);
    assign bus.cpu_write_ack = (state_q == ACK) && (op_q == CPU_WR);
    assign bus.busy          = (state_q != IDLE);
    assign bus.err           = err_q;

endmodule

// File: tb/tb_ram_controller.sv
// Drives two controllers (WAIT_STATES=0 and WAIT_STATES=1) with identical
// request streams and checks each against a per-instance memory model and
// the handshake latency rule: ack sampled high at edge N+1+WAIT_STATES.
module tb_ram_controller;

    localparam int OP_LD = 0;
    localparam int OP_RD = 1;
    localparam int OP_WR = 2;
    localparam int OP_RW = 3;

    logic clk;
    logic reset;

    logic [7:0]  drv_cpu_addr;
    logic [31:0] drv_cpu_wdata;
    logic        drv_cpu_rd;
    logic        drv_cpu_wr;
    logic [7:0]  drv_ld_addr;
    logic [31:0] drv_ld_wdata;
    logic        drv_ld_wr;

    ram_controller_if if0 ();
    ram_controller_if if1 ();

    assign if0.cpu_addr      = drv_cpu_addr;
    assign if0.cpu_wdata     = drv_cpu_wdata;
    assign if0.cpu_read_req  = drv_cpu_rd;
    assign if0.cpu_write_req = drv_cpu_wr;
    assign if0.ld_addr       = drv_ld_addr;
    assign if0.ld_wdata      = drv_ld_wdata;
    assign if0.ld_write_req  = drv_ld_wr;
    assign if1.cpu_addr      = drv_cpu_addr;
    assign if1.cpu_wdata     = drv_cpu_wdata;
    assign if1.cpu_read_req  = drv_cpu_rd;
    assign if1.cpu_write_req = drv_cpu_wr;
    assign if1.ld_addr       = drv_ld_addr;
    assign if1.ld_wdata      = drv_ld_wdata;
    assign if1.ld_write_req  = drv_ld_wr;

    ram_controller #(.WAIT_STATES(0), .WORDS(64)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (if0)
    );

    ram_controller #(.WAIT_STATES(1), .WORDS(64)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1)
    );

    // Index d of these vectors is the instance with WAIT_STATES = d.
    logic [1:0]  ld_ack_w, rd_ack_w, wr_ack_w, busy_w, err_w;
    logic [31:0] rdata_w [2];
    assign ld_ack_w   = {if1.ld_write_ack, if0.ld_write_ack};
    assign rd_ack_w   = {if1.cpu_read_ack, if0.cpu_read_ack};
    assign wr_ack_w   = {if1.cpu_write_ack, if0.cpu_write_ack};
    assign busy_w     = {if1.busy, if0.busy};
    assign err_w      = {if1.err, if0.err};
    assign rdata_w[0] = if0.cpu_rdata;
    assign rdata_w[1] = if1.cpu_rdata;

    // Reference state.
    logic [31:0] mem_m [2][64];
    logic [31:0] last_rd [2];
    bit          err_exp;

    int vectors;
    int miscompares;

    logic [7:0]  tmp_a, tmp_b;
    logic [31:0] tmp_d;
    int          exp_j;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int d, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s ws%0d observed=%h expected=%h", tag, d, obs, exp_v);
        end
    endtask

    task automatic reset_chk();
        for (int d = 0; d < 2; d++) begin
            chk("rst_busy", d, busy_w[d], 0);
            chk("rst_ld_ack", d, ld_ack_w[d], 0);
            chk("rst_rd_ack", d, rd_ack_w[d], 0);
            chk("rst_wr_ack", d, wr_ack_w[d], 0);
            chk("rst_err", d, err_w[d], 0);
            chk("rst_rdata", d, rdata_w[d], 0);
        end
    endtask

    // One complete handshake; the request is held `extra` cycles past the
    // last ack, then dropped, and the next request may follow one cycle later.
    task automatic txn(input int op, input logic [7:0] a, input logic [31:0] data,
                       input int extra, input bit rel_reset);
        int  idx;
        bit  is_rd;
        idx   = int'(a[7:2]);
        is_rd = (op == OP_RD) || (op == OP_RW);
        @(negedge clk);
        if (rel_reset) reset = 1'b0;
        drv_cpu_addr  = 8'($urandom);
        drv_cpu_wdata = $urandom;
        drv_ld_addr   = 8'($urandom);
        drv_ld_wdata  = $urandom;
        drv_cpu_rd = 1'b0; drv_cpu_wr = 1'b0; drv_ld_wr = 1'b0;
        case (op)
            OP_LD: begin drv_ld_addr = a; drv_ld_wdata = data; drv_ld_wr = 1'b1; end
            OP_RD: begin drv_cpu_addr = a; drv_cpu_rd = 1'b1; end
            OP_WR: begin drv_cpu_addr = a; drv_cpu_wdata = data; drv_cpu_wr = 1'b1; end
            default: begin
                drv_cpu_addr = a; drv_cpu_wdata = data;
                drv_cpu_rd = 1'b1; drv_cpu_wr = 1'b1;
            end
        endcase
        if (a[1:0] != 2'b00 || op == OP_RW) err_exp = 1'b1;
        @(posedge clk);
        for (int j = 0; j <= 1 + extra; j++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                chk("ld_ack", d, ld_ack_w[d], (op == OP_LD && j == d));
                chk("rd_ack", d, rd_ack_w[d], (is_rd && j == d));
                chk("wr_ack", d, wr_ack_w[d], (op == OP_WR && j == d));
                chk("busy", d, busy_w[d], 1);
                if (is_rd && j == d) begin
                    chk("rdata", d, rdata_w[d], mem_m[d][idx]);
                    last_rd[d] = mem_m[d][idx];
                end
            end
        end
        if (op == OP_LD || op == OP_WR) begin
            mem_m[0][idx] = data;
            mem_m[1][idx] = data;
        end
        drv_cpu_rd = 1'b0; drv_cpu_wr = 1'b0; drv_ld_wr = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("idle_busy", d, busy_w[d], 0);
            chk("err", d, err_w[d], err_exp);
            chk("rdata_hold", d, rdata_w[d], last_rd[d]);
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        err_exp = 1'b0;
        last_rd[0] = 32'h0; last_rd[1] = 32'h0;
        for (int d = 0; d < 2; d++)
            for (int w = 0; w < 64; w++) mem_m[d][w] = 32'h0;
        reset = 1'b1;
        drv_cpu_addr = 8'h00; drv_cpu_wdata = 32'h0; drv_cpu_rd = 1'b0; drv_cpu_wr = 1'b0;
        drv_ld_addr = 8'h00; drv_ld_wdata = 32'h0; drv_ld_wr = 1'b0;

        // Reset state, during and after reset.
        repeat (3) @(negedge clk);
        reset_chk();
        reset = 1'b0;
        @(negedge clk);
        reset_chk();

        // Preload through the loader; the first word is a known constant.
        txn(OP_LD, 8'h00, 32'h0000_0A01, 0, 0);
        for (int i = 1; i < 64; i++) txn(OP_LD, 8'(i * 4), $urandom, 0, 0);
        txn(OP_RD, 8'h00, 32'h0, 0, 0);

        // Write then read back near the top of the map.
        txn(OP_WR, 8'h3C, 32'hDEAD_BEEF, 0, 0);
        txn(OP_RD, 8'h3C, 32'h0, 0, 0);
        txn(OP_WR, 8'hFC, $urandom, 0, 0);
        txn(OP_RD, 8'hFC, 32'h0, 0, 0);

        // Read held three cycles past the ack: exactly one ack.
        txn(OP_RD, 8'(4 * $urandom_range(0, 63)), 32'h0, 3, 0);

        // Loader and CPU read rise together: loader first, then the read.
        @(negedge clk);
        tmp_a = 8'(4 * $urandom_range(0, 63));
        tmp_b = 8'(4 * $urandom_range(0, 63));
        tmp_d = $urandom;
        drv_ld_addr = tmp_a; drv_ld_wdata = tmp_d; drv_ld_wr = 1'b1;
        drv_cpu_addr = tmp_b; drv_cpu_rd = 1'b1;
        mem_m[0][tmp_a[7:2]] = tmp_d;
        mem_m[1][tmp_a[7:2]] = tmp_d;
        @(posedge clk);
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                // Loader ack at j=d, released at edge d+2, read accepted at
                // edge d+3, read ack d cycles later.
                exp_j = 3 + 2 * d;
                chk("pri_ld_ack", d, ld_ack_w[d], (j == d));
                chk("pri_rd_ack", d, rd_ack_w[d], (j == exp_j));
                chk("pri_wr_ack", d, wr_ack_w[d], 0);
                if (j == exp_j) begin
                    chk("pri_rdata", d, rdata_w[d], mem_m[d][tmp_b[7:2]]);
                    last_rd[d] = mem_m[d][tmp_b[7:2]];
                end
            end
            if (j == 1) drv_ld_wr = 1'b0;
        end
        drv_cpu_rd = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("pri_busy", d, busy_w[d], 0);
            chk("pri_err", d, err_w[d], 0);
        end

        // Random aligned traffic: err must stay clear.
        for (int i = 0; i < 30; i++)
            txn($urandom_range(0, 2), 8'(4 * $urandom_range(0, 63)), $urandom,
                $urandom_range(0, 2), 0);

        // Read and write together at 8'h11: word 4 read, no write, err set.
        txn(OP_RW, 8'h11, $urandom, 0, 0);
        txn(OP_RD, 8'h10, 32'h0, 0, 0);

        // Random traffic with any byte address.
        for (int i = 0; i < 20; i++)
            txn($urandom_range(0, 2), 8'($urandom), $urandom, $urandom_range(0, 1), 0);

        // Reset while the WAIT_STATES=1 instance waits on a write to 8'h08.
        @(negedge clk);
        tmp_d = $urandom;
        drv_cpu_addr = 8'h08; drv_cpu_wdata = tmp_d; drv_cpu_wr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rw_wr_ack", 0, wr_ack_w[0], 1);
        chk("rw_wr_ack", 1, wr_ack_w[1], 0);
        chk("rw_busy", 1, busy_w[1], 1);
        reset = 1'b1;
        drv_cpu_wr = 1'b0;
        #1;
        mem_m[0][2] = tmp_d;
        last_rd[0] = 32'h0; last_rd[1] = 32'h0;
        err_exp = 1'b0;
        reset_chk();
        @(negedge clk);
        reset_chk();
        // A read already high when reset releases is served as a new request.
        drv_cpu_addr = 8'h08; drv_cpu_rd = 1'b1;
        @(negedge clk);
        reset_chk();
        txn(OP_RD, 8'h08, 32'h0, 0, 1);

        for (int i = 0; i < 6; i++)
            txn($urandom_range(0, 2), 8'(4 * $urandom_range(0, 63)), $urandom, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ram_controller.md
RAM_CONTROLLER -- requirements
Module: ram_controller

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 1; extra cycles inserted before each ack, range 0..7.
REQ-002 SHALL have parameter WORDS, default 64; 32-bit words of storage.
REQ-003 SHALL have port clk, input, 1; clock, all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1; asynchronous, active-high.
REQ-005 SHALL have port cpu_addr, input, 8; byte address; bits [7:2] select the word.
REQ-006 SHALL have port cpu_wdata, input, 32; CPU write data.
REQ-007 SHALL have port cpu_read_req, input, 1; CPU read request, held until ack seen.
REQ-008 SHALL have port cpu_write_req, input, 1; CPU write request, held until ack seen.
REQ-009 SHALL have port cpu_rdata, output, 32; read data.
REQ-010 SHALL have port cpu_read_ack, output, 1; one-cycle read acknowledge.
REQ-011 SHALL have port cpu_write_ack, output, 1; one-cycle write acknowledge.
REQ-012 SHALL have loader ports ld_addr (input, 8), ld_wdata (input, 32), ld_write_req (input, 1) and ld_write_ack (output, 1), for program preload.
REQ-013 SHALL have port busy, output, 1; high whenever state is not IDLE.
REQ-014 SHALL have port err, output, 1; sticky protocol-error flag.

Function
REQ-015 SHALL implement FSM IDLE -> WAIT -> ACK -> RELEASE -> IDLE; WAIT is skipped when WAIT_STATES=0.
REQ-016 IDLE SHALL sample requests each edge; on acceptance it SHALL latch the address, data and operation and go to WAIT.
REQ-017 Priority in IDLE SHALL be ld_write_req, then cpu_read_req, then cpu_write_req.
REQ-018 cpu_read_req and cpu_write_req both sampled high SHALL serve the read and set err.
REQ-019 WAIT SHALL count WAIT_STATES cycles on a 3-bit counter, then go to ACK.
REQ-020 ACK SHALL last exactly one cycle and assert only the ack matching the latched operation.
REQ-021 On the edge entering ACK, a read SHALL load cpu_rdata from word addr[7:2], and a write SHALL commit wdata to that word.
REQ-022 cpu_rdata SHALL hold its value until the next accepted read.
REQ-023 Latency SHALL be as follows: request sampled at edge N gives ack high from edge N+1+WAIT_STATES for exactly one cycle.
REQ-024 RELEASE SHALL hold until the served request is sampled low, then return to IDLE; a still-high request SHALL never be served twice.
REQ-025 The minimum turnaround between back-to-back CPU requests (request low one cycle, then high) SHALL be accepted without loss.
REQ-026 A nonzero addr[1:0] on an accepted access SHALL set err; the access SHALL proceed word-aligned.
REQ-027 Address wrap: the maximum address 8'hFC SHALL map to word 63; there is no out-of-range case when WORDS=64.
REQ-028 A loader request arriving while a CPU access is in flight SHALL wait; no preemption.

Reset
REQ-029 Reset SHALL force state to IDLE, all acks to 0, busy to 0, err to 0, cpu_rdata to 0 and the wait counter to 0.
REQ-030 Storage contents SHALL NOT be reset.
REQ-031 A write not yet committed when reset asserts SHALL be dropped; committed writes SHALL persist.
REQ-032 After reset deasserts, a request already high SHALL be treated as new.

Structure
REQ-033 Package ram_pkg SHALL hold the state enum, the WORDS default, the word-index width and the op-type encoding (LD_WR, CPU_RD, CPU_WR).
REQ-034 Storage SHALL be a sub-module ram_array: single-port, synchronous, WORDS x 32, with write enable, no reset.

Verification
REQ-035 Loader writes 32'h0000_0A01 at 8'h00 -> ld_write_ack pulses at edge N+2 (WAIT_STATES=1); a CPU read at 8'h00 then returns 32'h0000_0A01.
REQ-036 CPU write of 32'hDEAD_BEEF at 8'h3C, then read of 8'h3C with WAIT_STATES=0 -> cpu_read_ack arrives 1 cycle after sampling and cpu_rdata = 32'hDEAD_BEEF.
REQ-037 cpu_read_req held high 3 cycles past ack -> exactly one ack; the controller stays in RELEASE until the request drops.
REQ-038 ld_write_req and cpu_read_req rise on the same edge -> loader served first, CPU read acked after its RELEASE; err stays 0.
REQ-039 cpu_read_req and cpu_write_req both high at 8'h11 -> read of word 4 served, err = 1, no write.
REQ-040 Reset pulsed during WAIT of a write to 8'h08 -> word 2 unchanged, no ack, busy = 0.
